// File: rtl/reset_sequencer.sv
// reset_sequencer
// Turns one raw asynchronous active-low board reset and a software reset
// request into NUM_OUT ordered active-low resets. All outputs assert at once.
// They release one at a time, in ascending index order, after a hold delay
// and then fixed step delays.
//
// Optional build macro RST_SEQ_ACK_EN adds a stage_ack input. With it, each
// step, and the final done pulse, waits for the previous stage to acknowledge
// its release.
module reset_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_rst_req,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_OUT-1:0] stage_ack,
`endif
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    // The terminal counts are equality compares against parameter-1, so the
    // counter never wraps.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_OUT-1:0]     rel_q, rel_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   step_armed;

`ifdef RST_SEQ_ACK_EN
    logic                   acked_q, acked_d;
    logic [IDX_W-1:0]       ack_idx;

    // In STEP, idx_q names the next output to release. The stage whose
    // acknowledge is awaited is therefore idx_q-1.
    assign ack_idx    = idx_q - IDX_W'(1);
    assign step_armed = acked_q;
`else
    assign step_armed = 1'b1;
`endif

    // Reset-release synchronizer: asserts with the raw reset and shifts in
    // ones after it rises. The last stage is the safe "reset removed" flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // Next-state logic. A software request overrides everything else on the
    // same edge, including a release or done that would otherwise happen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef RST_SEQ_ACK_EN
        acked_d = acked_q;
`endif

        if (sw_rst_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
            busy_d  = 1'b1;
`ifdef RST_SEQ_ACK_EN
            acked_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (sync_ok) begin
                        if (cnt_q == HOLD_LAST) begin
                            rel_d[0] = 1'b1;
                            cnt_d    = '0;
                            if (NUM_OUT == 1) begin
                                state_d = ST_RUN;
`ifndef RST_SEQ_ACK_EN
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
`endif
                            end else begin
                                state_d = ST_STEP;
                                idx_d   = IDX_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                ST_STEP: begin
                    if (!step_armed) begin
`ifdef RST_SEQ_ACK_EN
                        if (stage_ack[ack_idx]) begin
                            acked_d = 1'b1;
                        end
`endif
                    end else if (cnt_q == STEP_LAST) begin
                        rel_d[idx_q] = 1'b1;
                        cnt_d        = '0;
`ifdef RST_SEQ_ACK_EN
                        acked_d      = 1'b0;
`endif
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
`ifndef RST_SEQ_ACK_EN
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
`endif
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                ST_RUN: begin
`ifdef RST_SEQ_ACK_EN
                    // The sequence only completes once the last stage
                    // acknowledges its release.
                    if (busy_q && stage_ack[NUM_OUT-1]) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
`endif
                end

                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rel_d   = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs. The raw reset forces the
    // reset values immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef RST_SEQ_ACK_EN
            acked_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RST_SEQ_ACK_EN
            acked_q <= acked_d;
`endif
        end
    end

    assign rst_n_out = rel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer.
// The reference model computes each output's release edge from the
// sequencing rules: releases are counted from the first counting edge (base).
// It does not track the design's counter or state encoding.
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int NUM_OUT = 4;
    localparam int SYNC    = 2;
    localparam int HOLD    = 16;
    localparam int STEP    = 8;
`ifdef RST_SEQ_ACK_EN
    localparam int EXTRA   = 1;
`else
    localparam int EXTRA   = 0;
`endif
    localparam int VW      = NUM_OUT + 4;

    logic               clk    = 1'b0;
    logic               resetN = 1'b1;
    logic               swReq  = 1'b0;
    logic [NUM_OUT-1:0] rstNOut;
    logic               busy;
    logic               done;
    logic [1:0]         stateOut;

    logic               resetC = 1'b1;
    logic [0:0]         rstC;
    logic               busyC;
    logic               doneC;
    logic [1:0]         stateC;

`ifdef RST_SEQ_ACK_EN
    logic [NUM_OUT-1:0] stageAck = '1;
`endif

    int total = 0;
    int bad   = 0;

    int edgeNum = 0;
    int base    = SYNC + 1;
    bit swHit   = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
        .STEP_CYCLES(STEP), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(resetN),
        .sw_rst_req(swReq),
`ifdef RST_SEQ_ACK_EN
        .stage_ack(stageAck),
`endif
        .rst_n_out(rstNOut),
        .busy(busy),
        .done(done),
        .state(stateOut)
    );

    reset_sequencer #(
        .NUM_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(1),
        .STEP_CYCLES(8), .CNT_W(8)
    ) dutC (
        .clk(clk),
        .reset(resetC),
        .sw_rst_req(1'b0),
`ifdef RST_SEQ_ACK_EN
        .stage_ack(1'b1),
`endif
        .rst_n_out(rstC),
        .busy(busyC),
        .done(doneC),
        .state(stateC)
    );

    // Edge at which output k releases, counted from the first counting edge.
    function automatic int relEdge(input int k);
        return base + HOLD - 1 + k * (STEP + EXTRA);
    endfunction

    // Expected {rst_n_out, busy, done, state} after the current edge.
    function automatic logic [VW-1:0] expectedVec();
        logic [NUM_OUT-1:0] r;
        int                 m;
        int                 doneEdge;
        logic [1:0]         st;
        r = '0;
        if (!resetN || edgeNum == 0 || swHit) return {r, 1'b1, 1'b0, 2'd0};
        m = 0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (edgeNum >= relEdge(k)) begin
                r[k] = 1'b1;
                m++;
            end
        end
        doneEdge = relEdge(NUM_OUT - 1) + EXTRA;
        if (m == 0)            st = 2'd0;
        else if (m < NUM_OUT)  st = 2'd1;
        else                   st = 2'd2;
        return {r, (edgeNum < doneEdge), (edgeNum == doneEdge), st};
    endfunction

    function automatic logic [VW-1:0] obsVec();
        return {rstNOut, busy, done, stateOut};
    endfunction

    // Drives the raw reset. Asserting it restarts the model's edge numbering.
    task automatic setReset(input logic lvl);
        resetN = lvl;
        if (!lvl) begin
            edgeNum = 0;
            base    = SYNC + 1;
            swHit   = 1'b0;
        end
    endtask

    // Advances one clock edge, updates the model, and returns 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (resetN) begin
            edgeNum++;
            swHit = swReq;
            if (swReq) base = (edgeNum + 1 > SYNC + 1) ? edgeNum + 1 : SYNC + 1;
        end else begin
            swHit = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        setReset(1'b0);
        #1;
        total++;
        if (obsVec() !== expectedVec()) begin
            bad++;
            $display("[TB] FAIL reset_async: got %b expected %b", obsVec(), expectedVec());
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, obsVec(), expectedVec());
            end
        end
    endtask

    task automatic test_power_on();
        int last;
        setReset(1'b0);
        swReq = 1'b0;
        repeat (5) tick();
        setReset(1'b1);
        last = relEdge(NUM_OUT - 1) + EXTRA + 4;
        while (edgeNum < last) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL power_on edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
    endtask

    task automatic test_async_mid();
        int last;
        setReset(1'b0);
        repeat (3) tick();
        setReset(1'b1);
        while (edgeNum < 30) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL async_pre edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
        total++;
        if (rstNOut[1:0] !== 2'b11) begin
            bad++;
            $display("[TB] FAIL async_two_released: got %b expected 11", rstNOut[1:0]);
        end
        setReset(1'b0);
        #1;
        total++;
        if (obsVec() !== {{NUM_OUT{1'b0}}, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL async_drop: got %b expected %b", obsVec(), {{NUM_OUT{1'b0}}, 1'b1, 1'b0, 2'd0});
        end
        repeat (2) tick();
        setReset(1'b1);
        last = relEdge(NUM_OUT - 1) + EXTRA + 3;
        while (edgeNum < last) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL async_repeat edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
    endtask

    task automatic test_sw_run();
        while (edgeNum < 99) tick();
        swReq = 1'b1;
        while (edgeNum < 102) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL sw_run_high edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
        swReq = 1'b0;
        while (edgeNum < 150) begin
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL sw_run_after edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
    endtask

    task automatic test_sw_collide();
        int target;
        int sawDone;
        setReset(1'b0);
        repeat (2) tick();
        setReset(1'b1);
        target = relEdge(2);
        while (edgeNum < target - 1) tick();
        swReq = 1'b1;
        tick();
        total++;
        if (obsVec() !== {{NUM_OUT{1'b0}}, 1'b1, 1'b0, 2'd0}) begin
            bad++;
            $display("[TB] FAIL sw_collide edge %0d: got %b expected %b", edgeNum, obsVec(), {{NUM_OUT{1'b0}}, 1'b1, 1'b0, 2'd0});
        end
        swReq = 1'b0;
        sawDone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) sawDone++;
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL sw_collide_after edge %0d: got %b expected %b", edgeNum, obsVec(), expectedVec());
            end
        end
        total++;
        if (sawDone !== 0) begin
            bad++;
            $display("[TB] FAIL sw_collide_nodone: got %0d pulses expected 0", sawDone);
        end
    endtask

    task automatic test_corner();
        logic [4:0] want;
        resetC = 1'b0;
        #1;
        total++;
        if ({rstC, busyC, doneC, stateC} !== 5'b0_1_0_00) begin
            bad++;
            $display("[TB] FAIL corner_reset: got %b expected 01000", {rstC, busyC, doneC, stateC});
        end
        @(posedge clk);
        #1;
        resetC = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            want = {(e >= 3), (e < 3 + EXTRA), (e == 3 + EXTRA), ((e >= 3) ? 2'd2 : 2'd0)};
            total++;
            if ({rstC, busyC, doneC, stateC} !== want) begin
                bad++;
                $display("[TB] FAIL corner edge %0d: got %b expected %b", e, {rstC, busyC, doneC, stateC}, want);
            end
        end
    endtask

`ifdef RST_SEQ_ACK_EN
    task automatic test_ack();
        int ackEdge;
        setReset(1'b0);
        stageAck = 4'b1110;
        repeat (2) tick();
        setReset(1'b1);
        while (edgeNum < relEdge(0) + 20) begin
            tick();
            total++;
            if (rstNOut[1] !== 1'b0 || rstNOut[0] !== (edgeNum >= relEdge(0))) begin
                bad++;
                $display("[TB] FAIL ack_wait edge %0d: got %b", edgeNum, rstNOut);
            end
        end
        stageAck = 4'b1111;
        ackEdge = edgeNum + 1;
        while (edgeNum < ackEdge + STEP + 1) begin
            tick();
            total++;
            if (rstNOut[1] !== (edgeNum >= ackEdge + STEP)) begin
                bad++;
                $display("[TB] FAIL ack_release edge %0d: got %b expected %b", edgeNum, rstNOut[1], (edgeNum >= ackEdge + STEP));
            end
        end
        setReset(1'b0);
        tick();
    endtask
`endif

    task automatic test_random();
        int rstHold;
        rstHold = 0;
        setReset(1'b0);
        swReq = 1'b0;
        repeat (2) tick();
        setReset(1'b1);
        for (int i = 0; i < 900; i++) begin
            if (rstHold > 0) begin
                rstHold--;
                if (rstHold == 0) setReset(1'b1);
            end else if ($urandom_range(0, 249) == 0) begin
                setReset(1'b0);
                rstHold = $urandom_range(1, 3);
                #1;
                total++;
                if (obsVec() !== expectedVec()) begin
                    bad++;
                    $display("[TB] FAIL random_async i=%0d: got %b expected %b", i, obsVec(), expectedVec());
                end
            end
            if (swReq) swReq = ($urandom_range(0, 2) != 0);
            else       swReq = ($urandom_range(0, 69) == 0);
            tick();
            total++;
            if (obsVec() !== expectedVec()) begin
                bad++;
                $display("[TB] FAIL random i=%0d edge %0d: got %b expected %b", i, edgeNum, obsVec(), expectedVec());
            end
        end
        swReq = 1'b0;
    endtask

    initial begin
        $display("[TB] reset_sequencer bench start");
        test_reset();
        test_power_on();
        test_async_mid();
        test_sw_run();
        test_sw_collide();
        test_corner();
`ifdef RST_SEQ_ACK_EN
        test_ack();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Generates the ordered, synchronously released active-low resets that feed the block's async-reset flops.
- Takes one raw async active-low reset and one software reset request.
- Drives NUM_OUT reset outputs. All outputs assert immediately; they deassert one at a time, in index order, with programmed hold and step delays.
- Sits at the top level between the board reset pin and all downstream register banks.

Parameters:
- NUM_OUT, 4: number of sequenced reset outputs (>=1).
- SYNC_STAGES, 2: depth of the reset-release synchronizer (>=2).
- HOLD_CYCLES, 16: counted cycles from sync release (or software request removal) to release of output 0 (>=1).
- STEP_CYCLES, 8: cycles between successive output releases (>=1).
- CNT_W, 8: width of the shared delay counter. Must hold max(HOLD_CYCLES, STEP_CYCLES).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion acts immediately; deassertion is synchronized internally.
- sw_rst_req  input  1  synchronous software reset request, active-high, level.
- rst_n_out  output  NUM_OUT  sequenced active-low resets; bit 0 releases first.
- busy  output  1  high whenever the sequence is not complete.
- done  output  1  single-cycle pulse when the last output releases.
- state  output  2  debug encoding: 0 HOLD, 1 STEP, 2 RUN.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on port reset. All flops use it.
- Reset values: rst_n_out=all 0, busy=1, done=0, state=HOLD, counter=0, output index=0, synchronizer chain=0.
- Reset assertion forces these values asynchronously, in any state, with no clock required.
- Synchronizer: a SYNC_STAGES-deep chain shifts in 1 once reset is high. sync_ok goes high after edge SYNC_STAGES, where edge 1 is the first rising edge with reset high.
- HOLD state:
  - The counter increments on each edge with sync_ok=1 and sw_rst_req=0.
  - On the HOLD_CYCLES-th counting edge: rst_n_out[0] goes 1, counter clears, next state is STEP, or RUN if NUM_OUT=1.
  - Power-on timing: output 0 releases at edge SYNC_STAGES+HOLD_CYCLES (defaults: edge 18).
- STEP state:
  - The counter increments each edge.
  - On the STEP_CYCLES-th edge the next output index releases and the counter clears.
  - Output k releases at edge SYNC_STAGES+HOLD_CYCLES+k*STEP_CYCLES (defaults: 18, 26, 34, 42).
  - Released outputs stay 1. Outputs only ever release in ascending index order.
- RUN state: entered on the edge that releases output NUM_OUT-1.
  - done is 1 for exactly that one following cycle.
  - busy is 0 from that edge onward.
- Software request:
  - sw_rst_req sampled high at any edge, in any state: all rst_n_out=0, busy=1, done=0, counter=0, state=HOLD, at that edge.
  - Counting is held while the request stays high.
  - If F is the first edge sampling it low, output 0 releases at edge F+HOLD_CYCLES-1. The remaining outputs follow at STEP_CYCLES spacing.
- Simultaneous events:
  - The async reset dominates everything.
  - sw_rst_req dominates a release or done on the same edge; that release and done are cancelled.
- Counter: no wrap is permitted. The terminal compare is an equality compare against the parameter minus 1.

Optional Feature:
- Macro: RST_SEQ_ACK_EN.
- Defined:
  - Adds input stage_ack[NUM_OUT-1:0] (active-high, synchronous).
  - After output k releases, the STEP counter for output k+1 stays at 0 until stage_ack[k] is sampled high. Counting starts on the edge after that ack.
  - done waits for stage_ack[NUM_OUT-1] to be sampled high.
  - sw_rst_req and reset still abort immediately.
  - Ack bits of unreleased stages are ignored.
- Undefined: the port is absent and timing is purely counter-based as above.

Test Plan:
- Power-on, defaults: reset low 5 cycles then high. Required: rst_n_out bits rise at edges 18/26/34/42 in order 0..3; done pulses one cycle after edge 42; busy falls at edge 42; state reads 2.
- Async mid-sequence: drop reset between edges 30 and 31, with outputs 0 and 1 released. Required: rst_n_out=0000, busy=1, state=0 before the next edge. After re-release, the full power-on timing repeats.
- Software request in RUN: sw_rst_req high at edges 100..102, low at 103. Required: all outputs 0 at edge 100; output 0 at edge 118; output 3 at edge 142; done one cycle after 142.
- Request during STEP, coinciding with the release edge of output 2: required: output 2 not released; all outputs 0; no done pulse.
- Parameter corner NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=2: required: rst_n_out[0] rises at edge 3 with done the following cycle.
- RST_SEQ_ACK_EN build: withhold stage_ack[0] for 20 cycles after output 0 releases. Required: output 1 releases STEP_CYCLES edges after the ack-sample edge, not at edge 26.
